// File: rtl/xor_nand_sched.sv
`default_nettype none
// ============================================================================
// Module   : xor_nand_sched
// Function : Round-robin scheduler time-sharing one 4-NAND XOR cell, bit-serial
//            LSB first. Optional macro XOR_NAND_SCHED_PARITY_EN adds a parity
//            output built from a second 4-NAND cell.
// Revision : 1.0 - initial release
// ============================================================================
module xor_nand_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_flat,
    input  logic [NREQ*WIDTH-1:0]   b_flat,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic [WIDTH-1:0]        res,
    output logic                    res_valid,
    output logic [$clog2(NREQ)-1:0] res_id
`ifdef XOR_NAND_SCHED_PARITY_EN
    ,
    output logic                    parity
`endif
);

    localparam int IDW = $clog2(NREQ);
    localparam int SW  = IDW + 1;
    localparam int CW  = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [NREQ-1:0]  gnt_q,       gnt_d;
    logic             busy_q,      busy_d;
    logic [IDW-1:0]   res_id_q,    res_id_d;
    logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [WIDTH-1:0] a_sh_q,      a_sh_d;
    logic [WIDTH-1:0] b_sh_q,      b_sh_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] res_q,       res_d;
    logic             res_valid_q, res_valid_d;
`ifdef XOR_NAND_SCHED_PARITY_EN
    logic             par_acc_q,   par_acc_d;
    logic             parity_q,    parity_d;
`endif

    // Shared gate-level XOR cell on the current serial bit pair
    wire x_w1, x_w2, x_w3, x_z;
    nand u_xnand1 (x_w1, a_sh_q[0], b_sh_q[0]);
    nand u_xnand2 (x_w2, a_sh_q[0], x_w1);
    nand u_xnand3 (x_w3, b_sh_q[0], x_w1);
    nand u_xnand4 (x_z,  x_w2,      x_w3);

`ifdef XOR_NAND_SCHED_PARITY_EN
    wire p_w1, p_w2, p_w3, p_z;
    nand u_pnand1 (p_w1, par_acc_q, x_z);
    nand u_pnand2 (p_w2, par_acc_q, p_w1);
    nand u_pnand3 (p_w3, x_z,       p_w1);
    nand u_pnand4 (p_z,  p_w2,      p_w3);
`endif

    // Winner: first pending requester after rr_ptr, wrapping modulo NREQ
    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [SW-1:0]  scan;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan = {1'b0, rr_ptr_q} + SW'(k);
            if (scan >= SW'(NREQ)) scan = scan - SW'(NREQ);
            if (!win_found && req[scan[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[IDW-1:0];
            end
        end
    end

    logic [WIDTH-1:0] a_sel, b_sel;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (res_id_q == IDW'(i)) begin
                a_sel = a_flat[i*WIDTH +: WIDTH];
                b_sel = b_flat[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        busy_d      = busy_q;
        res_id_d    = res_id_q;
        rr_ptr_d    = rr_ptr_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
`ifdef XOR_NAND_SCHED_PARITY_EN
        par_acc_d   = par_acc_q;
        parity_d    = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                    res_id_d = win_idx;
                    busy_d   = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                a_sh_d    = a_sel;
                b_sh_d    = b_sel;
                acc_d     = '0;
                cnt_d     = '0;
`ifdef XOR_NAND_SCHED_PARITY_EN
                par_acc_d = 1'b0;
`endif
                state_d   = SHIFT;
            end
            SHIFT: begin
                a_sh_d    = a_sh_q >> 1;
                b_sh_d    = b_sh_q >> 1;
                // New bit enters at the MSB so the LSB-first stream lands in order
                acc_d     = WIDTH'({x_z, acc_q} >> 1);
                cnt_d     = cnt_q + 1'b1;
`ifdef XOR_NAND_SCHED_PARITY_EN
                par_acc_d = p_z;
`endif
                if (cnt_q == CNT_LAST) state_d = DONE;
            end
            DONE: begin
                res_d       = acc_q;
                res_valid_d = 1'b1;
                rr_ptr_d    = res_id_q;
                gnt_d       = '0;
                busy_d      = 1'b0;
`ifdef XOR_NAND_SCHED_PARITY_EN
                parity_d    = par_acc_q;
`endif
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            res_id_q    <= '0;
            rr_ptr_q    <= IDW'(NREQ - 1);
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
`ifdef XOR_NAND_SCHED_PARITY_EN
            par_acc_q   <= 1'b0;
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            res_id_q    <= res_id_d;
            rr_ptr_q    <= rr_ptr_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
`ifdef XOR_NAND_SCHED_PARITY_EN
            par_acc_q   <= par_acc_d;
            parity_q    <= parity_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
`ifdef XOR_NAND_SCHED_PARITY_EN
    assign parity    = parity_q;
`endif

endmodule
`default_nettype wire
